// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
//   bp_entry_t : one BTB/BHT entry {valid, tag, target, ctr}
//   CTR_*      : 2-bit saturating counter encodings
//   ctr_next   : saturating counter step toward the resolved direction
package bp_pkg;

   localparam int unsigned BP_ENTRIES = 64;
   localparam int unsigned BP_PC_W    = 32;
   localparam int unsigned BP_CNT_W   = 32;
   localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int unsigned BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_PC_W-1:0]  target;
      ctr_t                ctr;
   } bp_entry_t;

   // Saturating increment on taken, decrement on not taken.
   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != CTR_ST) res = ctr + 2'(1);
      end else begin
         if (ctr != CTR_SNT) res = ctr - 2'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB/BHT storage.
//   clk_i, rst_ni   : clock, synchronous active-low reset (clears valid, sets ctr to weakly not-taken)
//   rd_idx_i        : combinational lookup index; rd_entry_o returns the stored (pre-update) entry
//   upd_en_i        : train with a resolved branch/jump at upd_idx_i (hit: count/retarget, miss+taken: allocate)
//   inv_en_i        : invalidate the entry at upd_idx_i if its tag matches upd_tag_i (alias repair)
//   upd_tag_i, upd_taken_i, upd_jmp_i, upd_target_i : training payload
module bp_table
   import bp_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [BP_IDX_W-1:0] rd_idx_i,
   output bp_entry_t           rd_entry_o,
   input  logic                upd_en_i,
   input  logic                inv_en_i,
   input  logic [BP_IDX_W-1:0] upd_idx_i,
   input  logic [BP_TAG_W-1:0] upd_tag_i,
   input  logic                upd_taken_i,
   input  logic                upd_jmp_i,
   input  logic [BP_PC_W-1:0]  upd_target_i
);

   bp_entry_t tab [BP_ENTRIES];
   bp_entry_t upd_cur;
   logic      upd_hit;

   // Read port sees the old entry even when the same index is written this cycle.
   assign rd_entry_o = tab[rd_idx_i];

   // Hit status of the entry being trained.
   always_comb begin
      upd_cur = tab[upd_idx_i];
      upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag_i);
   end

   // Write port; reset drops any pending update. Tag/target are don't-care while invalid.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(BP_ENTRIES); i++) begin
            tab[i].valid <= 1'b0;
            tab[i].ctr   <= CTR_WNT;
         end
      end else if (upd_en_i) begin
         if (upd_hit) begin
            tab[upd_idx_i].ctr <= ctr_next(upd_cur.ctr, upd_taken_i);
            if (upd_taken_i) tab[upd_idx_i].target <= upd_target_i;
         end else if (upd_taken_i) begin
            tab[upd_idx_i].valid  <= 1'b1;
            tab[upd_idx_i].tag    <= upd_tag_i;
            tab[upd_idx_i].target <= upd_target_i;
            tab[upd_idx_i].ctr    <= upd_jmp_i ? CTR_ST : CTR_WT;
         end
      end else if (inv_en_i && upd_hit) begin
         tab[upd_idx_i].valid <= 1'b0;
      end
   end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Fetch-side branch predictor and redirect controller.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   if_pc_i                : fetch PC; pred_taken_o / pred_target_o are the same-cycle prediction
//   stall_i, ex_valid_i    : EX resolves only when valid and not stalled
//   ex_is_br_i, ex_is_jmp_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i : EX instruction and its carried prediction
//   ex_taken_i, ex_target_i: resolved outcome
//   redirect_o, redirect_pc_o, flush_if_id_o, flush_id_ex_o : combinational mispredict recovery
//   branch_cnt_o, mispred_cnt_o : wrapping event counters
module branch_pred_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned BHT_ENTRIES = BP_ENTRIES,
   parameter int unsigned PC_W        = BP_PC_W,
   parameter int unsigned CNT_W       = BP_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [PC_W-1:0]  if_pc_i,
   output logic             pred_taken_o,
   output logic [PC_W-1:0]  pred_target_o,
   input  logic             stall_i,
   input  logic             ex_valid_i,
   input  logic             ex_is_br_i,
   input  logic             ex_is_jmp_i,
   input  logic [PC_W-1:0]  ex_pc_i,
   input  logic             ex_pred_taken_i,
   input  logic [PC_W-1:0]  ex_pred_target_i,
   input  logic             ex_taken_i,
   input  logic [PC_W-1:0]  ex_target_i,
   output logic             redirect_o,
   output logic [PC_W-1:0]  redirect_pc_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   bp_entry_t       lk_entry;
   logic            lk_hit;
   logic            br_or_jmp;
   logic            resolve;
   logic            mis_dir;
   logic            mis_tgt;
   logic            mis_alias;
   logic            mispredict;
   logic [PC_W-1:0] ex_seq_pc;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_q;

   bp_table u_table (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rd_idx_i     (if_pc_i[IDX_W+1:2]),
      .rd_entry_o   (lk_entry),
      .upd_en_i     (resolve && br_or_jmp),
      .inv_en_i     (resolve && mis_alias),
      .upd_idx_i    (ex_pc_i[IDX_W+1:2]),
      .upd_tag_i    (ex_pc_i[PC_W-1:IDX_W+2]),
      .upd_taken_i  (ex_taken_i),
      .upd_jmp_i    (ex_is_jmp_i),
      .upd_target_i (ex_target_i)
   );

   // IF lookup: predict taken only on a tag hit with a taken-leaning counter.
   always_comb begin
      lk_hit        = lk_entry.valid && (lk_entry.tag == if_pc_i[PC_W-1:IDX_W+2]);
      pred_taken_o  = lk_hit && lk_entry.ctr[1];
      pred_target_o = pred_taken_o ? lk_entry.target : if_pc_i + PC_W'(4);
   end

   // EX compare: wrong direction, wrong target, or a non-branch that was predicted taken.
   always_comb begin
      br_or_jmp  = ex_is_br_i || ex_is_jmp_i;
      resolve    = ex_valid_i && !stall_i;
      ex_seq_pc  = ex_pc_i + PC_W'(4);
      mis_dir    = br_or_jmp && (ex_taken_i != ex_pred_taken_i);
      mis_tgt    = br_or_jmp && ex_taken_i && ex_pred_taken_i &&
                   (ex_target_i != ex_pred_target_i);
      mis_alias  = !br_or_jmp && ex_pred_taken_i;
      mispredict = resolve && (mis_dir || mis_tgt || mis_alias);
   end

   // Recovery outputs follow the mispredict in the same cycle.
   always_comb begin
      redirect_o    = mispredict;
      flush_if_id_o = mispredict;
      flush_id_ex_o = mispredict;
      redirect_pc_o = '0;
      if (mispredict) begin
         redirect_pc_o = (br_or_jmp && ex_taken_i) ? ex_target_i : ex_seq_pc;
      end
   end

   // Event counters, wrapping.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (resolve && br_or_jmp) branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
         if (mispredict)           mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a queued scoreboard and negedge monitor.
module tb_branch_pred_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        stall;
   logic        ex_valid, ex_is_br, ex_is_jmp;
   logic [31:0] ex_pc;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush_if_id, flush_id_ex;
   logic [31:0] branch_cnt, mispred_cnt;

   // Staged values applied just after the next rising edge.
   logic        nx_rst;
   logic        nx_stall, nx_valid, nx_br, nx_jmp, nx_ptk, nx_tk;
   logic [31:0] nx_pc, nx_ptg, nx_tg;

   typedef struct {
      int          id;
      logic        ptk;
      logic [31:0] ptgt;
      logic        rd;
      logic [31:0] rpc;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   branch_pred_ctrl dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .if_pc_i          (if_pc),
      .pred_taken_o     (pred_taken),
      .pred_target_o    (pred_target),
      .stall_i          (stall),
      .ex_valid_i       (ex_valid),
      .ex_is_br_i       (ex_is_br),
      .ex_is_jmp_i      (ex_is_jmp),
      .ex_pc_i          (ex_pc),
      .ex_pred_taken_i  (ex_pred_taken),
      .ex_pred_target_i (ex_pred_target),
      .ex_taken_i       (ex_taken),
      .ex_target_i      (ex_target),
      .redirect_o       (redirect),
      .redirect_pc_o    (redirect_pc),
      .flush_if_id_o    (flush_if_id),
      .flush_id_ex_o    (flush_id_ex),
      .branch_cnt_o     (branch_cnt),
      .mispred_cnt_o    (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s actual=%h expected=%h", id, nm, act, exp);
      end
   endtask

   // Monitor: every driven cycle presents a response; compare it to the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk(e.id, "pred_taken",  32'(pred_taken),  32'(e.ptk));
         chk(e.id, "pred_target", pred_target,      e.ptgt);
         chk(e.id, "redirect",    32'(redirect),    32'(e.rd));
         chk(e.id, "flush_if_id", 32'(flush_if_id), 32'(e.rd));
         chk(e.id, "flush_id_ex", 32'(flush_id_ex), 32'(e.rd));
         chk(e.id, "redirect_pc", redirect_pc,      e.rpc);
         chk(e.id, "branch_cnt",  branch_cnt,       e.bc);
         chk(e.id, "mispred_cnt", mispred_cnt,      e.mc);
      end
   end

   task automatic set_ex(input logic st, input logic v, input logic br, input logic jmp,
                         input logic [31:0] pc, input logic ptk, input logic [31:0] ptg,
                         input logic tk, input logic [31:0] tg);
      nx_stall = st; nx_valid = v; nx_br = br; nx_jmp = jmp;
      nx_pc = pc; nx_ptk = ptk; nx_ptg = ptg; nx_tk = tk; nx_tg = tg;
   endtask

   task automatic clr_ex();
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // One cycle: apply staged inputs after the edge and queue the expected response.
   task automatic step(input int id, input logic [31:0] ifpc,
                       input logic e_ptk, input logic [31:0] e_ptgt,
                       input logic e_rd, input logic [31:0] e_rpc,
                       input logic [31:0] e_bc, input logic [31:0] e_mc);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = nx_rst; if_pc = ifpc;
      stall = nx_stall; ex_valid = nx_valid; ex_is_br = nx_br; ex_is_jmp = nx_jmp;
      ex_pc = nx_pc; ex_pred_taken = nx_ptk; ex_pred_target = nx_ptg;
      ex_taken = nx_tk; ex_target = nx_tg;
      e.id = id; e.ptk = e_ptk; e.ptgt = e_ptgt; e.rd = e_rd; e.rpc = e_rpc;
      e.bc = e_bc; e.mc = e_mc;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0; if_pc = 32'h100;
      stall = 0; ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_pc = 0;
      ex_pred_taken = 0; ex_pred_target = 0; ex_taken = 0; ex_target = 0;
      nx_rst = 1'b0;
      clr_ex();
      repeat (2) @(posedge clk);
      nx_rst = 1'b1;

      // reset state
      step(1, 32'h100, 0, 32'h104, 0, 32'h0, 0, 0);

      // cold beq @0x200 taken to 0x180, predicted not taken
      set_ex(0, 1, 1, 0, 32'h200, 0, 32'h204, 1, 32'h180);
      step(2, 32'h100, 0, 32'h104, 1, 32'h180, 0, 0);
      clr_ex();
      step(3, 32'h200, 1, 32'h180, 0, 32'h0, 1, 1);

      // same beq taken twice (ctr 10->11->11), then not taken (->10)
      set_ex(0, 1, 1, 0, 32'h200, 1, 32'h180, 1, 32'h180);
      step(4, 32'h200, 1, 32'h180, 0, 32'h0, 1, 1);
      step(5, 32'h200, 1, 32'h180, 0, 32'h0, 2, 1);
      set_ex(0, 1, 1, 0, 32'h200, 1, 32'h180, 0, 32'h180);
      step(6, 32'h200, 1, 32'h180, 1, 32'h204, 3, 1);
      clr_ex();
      step(7, 32'h200, 1, 32'h180, 0, 32'h0, 4, 2);

      // jalr @0x240 wrong target; same-cycle lookup sees the old (empty) entry
      set_ex(0, 1, 0, 1, 32'h240, 1, 32'h300, 1, 32'h340);
      step(8, 32'h240, 0, 32'h244, 1, 32'h340, 4, 2);
      clr_ex();
      step(9, 32'h240, 1, 32'h340, 0, 32'h0, 5, 3);

      // stalled mispredicting EX held for 3 cycles, resolves once
      set_ex(1, 1, 1, 0, 32'h280, 0, 32'h284, 1, 32'h2c0);
      step(10, 32'h280, 0, 32'h284, 0, 32'h0, 5, 3);
      step(11, 32'h280, 0, 32'h284, 0, 32'h0, 5, 3);
      step(12, 32'h280, 0, 32'h284, 0, 32'h0, 5, 3);
      set_ex(0, 1, 1, 0, 32'h280, 0, 32'h284, 1, 32'h2c0);
      step(13, 32'h280, 0, 32'h284, 1, 32'h2c0, 5, 3);
      clr_ex();
      step(14, 32'h280, 1, 32'h2c0, 0, 32'h0, 6, 4);

      // index 0 tag mismatch; non-branch alias @0x300 redirects to 0x304, no invalidation
      set_ex(0, 1, 0, 0, 32'h300, 1, 32'h380, 0, 32'h0);
      step(15, 32'h300, 0, 32'h304, 1, 32'h304, 6, 4);
      clr_ex();
      step(16, 32'h200, 1, 32'h180, 0, 32'h0, 6, 5);

      // non-branch alias @0x200 with matching tag invalidates the entry
      set_ex(0, 1, 0, 0, 32'h200, 1, 32'h180, 0, 32'h0);
      step(17, 32'h100, 0, 32'h104, 1, 32'h204, 6, 5);
      clr_ex();
      step(18, 32'h200, 0, 32'h204, 0, 32'h0, 6, 6);

      // not-taken miss: counted, no allocation
      set_ex(0, 1, 1, 0, 32'h2c4, 0, 32'h2c8, 0, 32'h400);
      step(19, 32'h2c4, 0, 32'h2c8, 0, 32'h0, 6, 6);
      clr_ex();
      step(20, 32'h2c4, 0, 32'h2c8, 0, 32'h0, 7, 6);

      // mid-run reset drops the pending update and clears everything
      nx_rst = 1'b0;
      set_ex(0, 1, 1, 0, 32'h200, 0, 32'h204, 1, 32'h180);
      step(21, 32'h240, 1, 32'h340, 1, 32'h180, 7, 6);
      nx_rst = 1'b1;
      clr_ex();
      step(22, 32'h200, 0, 32'h204, 0, 32'h0, 0, 0);
      step(23, 32'h240, 0, 32'h244, 0, 32'h0, 0, 0);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
